// File: rtl/ddr_ctrl_pkg.sv
// Shared types and constants for the AXI-side data pool in front of the DDR3 core.
// Provides the read-FSM state encoding, default bus widths and the write-entry width helper.
// No ports; imported by the interface, FIFO and top.
package ddr_ctrl_pkg;

  localparam int AXI_DW_DEF = 256;
  localparam int AXI_AW_DEF = 32;

  // One write-FIFO entry is {addr, data, wstrb}.
  localparam int WENT_W_DEF = AXI_AW_DEF + AXI_DW_DEF + AXI_DW_DEF / 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_DRAIN = 3'd1,
    ST_RD_CMD     = 3'd2,
    ST_RD_RESP    = 3'd3,
    ST_RD_DONE    = 3'd4
  } rd_state_t;

  function automatic int went_w(input int aw, input int dw);
    return aw + dw + dw / 8;
  endfunction

endpackage

// File: rtl/axi_data_pool_if.sv
// Bundle of all handshake/bus signals of axi_data_pool (upstream AXI side and DRAM command side).
// slave modport: the data pool's view; master modport: the environment's view.
// Widths follow AXI_DW / AXI_AW; strobes are AXI_DW/8 bits.
interface axi_data_pool_if #(
  parameter int AXI_DW = 256,
  parameter int AXI_AW = 32
);

  // upstream (AXI slave logic) side
  logic                  write_req;
  logic [AXI_AW-1:0]     write_addr;
  logic [AXI_DW-1:0]     write_data;
  logic [AXI_DW/8-1:0]   write_wstrb;
  logic                  data_full;
  logic                  read_req;
  logic [AXI_AW-1:0]     read_addr;
  logic                  data_ready;
  logic                  data_ready_clear;
  logic [AXI_DW-1:0]     read_data;
  // DRAM core side
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [AXI_AW-1:0]     cmd_addr;
  logic [AXI_DW-1:0]     cmd_wdata;
  logic [AXI_DW/8-1:0]   cmd_wstrb;
  logic                  rsp_valid;
  logic [AXI_DW-1:0]     rsp_data;
  logic                  proto_err;

  modport slave (
    input  write_req, write_addr, write_data, write_wstrb,
    input  read_req, read_addr, data_ready_clear,
    input  cmd_ready, rsp_valid, rsp_data,
    output data_full, data_ready, read_data,
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, proto_err
  );

  modport master (
    output write_req, write_addr, write_data, write_wstrb,
    output read_req, read_addr, data_ready_clear,
    output cmd_ready, rsp_valid, rsp_data,
    input  data_full, data_ready, read_data,
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, proto_err
  );

endinterface

// File: rtl/dp_wfifo.sv
// Synchronous FIFO for posted write entries; dout shows the head combinationally from storage.
// Ports: clk, rst_n (async active-low), push/din, pop/dout, full, empty.
// Push while full and pop while empty are ignored; simultaneous push+pop keeps count.
module dp_wfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: the head is only consumed while count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_data_pool.sv
// Buffers posted single-beat writes and single-beat reads between AXI slave logic and the DRAM core.
// Ports: axi_clk, axi_rstn (async active-low), bus (slave modport: request, command and response lines).
// Writes drain first; a read is issued only once every earlier write has left the FIFO.
module axi_data_pool
  import ddr_ctrl_pkg::*;
#(
  parameter int AXI_DW   = AXI_DW_DEF,
  parameter int AXI_AW   = AXI_AW_DEF,
  parameter int WF_DEPTH = 4
) (
  input  logic            axi_clk,
  input  logic            axi_rstn,
  axi_data_pool_if.slave  bus
);

  localparam int SW     = AXI_DW / 8;
  localparam int WENT_W = went_w(AXI_AW, AXI_DW);

  logic              wr_q, rd_q;
  logic              wr_rise, rd_rise;
  logic              f_push, f_pop, f_full, f_empty;
  logic [WENT_W-1:0] f_din, f_dout;
  rd_state_t         state;
  logic [AXI_AW-1:0] rd_addr;
  logic [AXI_DW-1:0] rd_data;
  logic              wr_ack, rd_ack, perr;
  logic              wr_cmd;

  assign wr_rise = bus.write_req & ~wr_q;
  assign rd_rise = bus.read_req & ~rd_q;

  assign f_push = wr_rise & ~f_full;
  assign f_din  = {bus.write_addr, bus.write_data, bus.write_wstrb};
  // The FSM only enters RD_CMD with the FIFO empty; writes pushed later wait
  // behind the read so the presented command stays stable until accepted.
  assign wr_cmd = ~f_empty & (state != ST_RD_CMD);
  assign f_pop  = wr_cmd & bus.cmd_ready;

  dp_wfifo #(
    .WIDTH (WENT_W),
    .DEPTH (WF_DEPTH)
  ) u_wfifo (
    .clk   (axi_clk),
    .rst_n (axi_rstn),
    .push  (f_push),
    .pop   (f_pop),
    .din   (f_din),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty)
  );

  always_comb begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_wstrb = '0;
    if (state == ST_RD_CMD) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_addr  = rd_addr;
    end else if (wr_cmd) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = f_dout[WENT_W-1 -: AXI_AW];
      bus.cmd_wdata = f_dout[SW +: AXI_DW];
      bus.cmd_wstrb = f_dout[SW-1:0];
    end
  end

  assign bus.data_full  = f_full;
  assign bus.data_ready = wr_ack | rd_ack;
  assign bus.read_data  = rd_data;
  assign bus.proto_err  = perr;

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      state   <= ST_IDLE;
      rd_addr <= '0;
      rd_data <= '0;
      wr_ack  <= 1'b0;
      rd_ack  <= 1'b0;
      perr    <= 1'b0;
    end else begin
      wr_q <= bus.write_req;
      rd_q <= bus.read_req;

      // Posted-write completion: raised after an accepted push, dropped once
      // upstream lowers the request or clears it.
      if (f_push)
        wr_ack <= 1'b1;
      else if (!bus.write_req || bus.data_ready_clear)
        wr_ack <= 1'b0;

      if ((wr_rise && f_full) || (bus.rsp_valid && state != ST_RD_RESP))
        perr <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (rd_rise) begin
            rd_addr <= bus.read_addr;
            state   <= ST_WAIT_DRAIN;
          end
        end
        ST_WAIT_DRAIN: begin
          if (f_empty && !f_push) state <= ST_RD_CMD;
        end
        ST_RD_CMD: begin
          if (bus.cmd_ready) state <= ST_RD_RESP;
        end
        ST_RD_RESP: begin
          if (bus.rsp_valid) begin
            rd_data <= bus.rsp_data;
            rd_ack  <= 1'b1;
            state   <= ST_RD_DONE;
          end
        end
        ST_RD_DONE: begin
          if (bus.data_ready_clear || !bus.read_req) begin
            rd_ack <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_data_pool.sv
// Self-checking bench for axi_data_pool: vector table for write/drain/full, hand sequences for reads.
// Ports: none; drives the interface master side and the clock/reset.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_axi_data_pool;
  import ddr_ctrl_pkg::*;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_fail;

  axi_data_pool_if #(.AXI_DW(256), .AXI_AW(32)) bus ();

  axi_data_pool #(.AXI_DW(256), .AXI_AW(32), .WF_DEPTH(4)) dut (
    .axi_clk  (clk),
    .axi_rstn (rstn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        crdy;
    logic [31:0] addr;
    logic [7:0]  db;
    logic        e_dr;
    logic        e_full;
    logic        e_cv;
    logic        e_cw;
    logic [31:0] e_caddr;
    logic [7:0]  e_cdb;
    logic        e_perr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic wr, logic crdy, logic [31:0] a, logic [7:0] d,
                              logic dr, logic full, logic cv, logic cw,
                              logic [31:0] ca, logic [7:0] cd, logic pe);
    vec_t v;
    v.wr = wr; v.crdy = crdy; v.addr = a; v.db = d;
    v.e_dr = dr; v.e_full = full; v.e_cv = cv; v.e_cw = cw;
    v.e_caddr = ca; v.e_cdb = cd; v.e_perr = pe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.write_req = 0; bus.write_addr = '0; bus.write_data = '0; bus.write_wstrb = '0;
    bus.read_req = 0; bus.read_addr = '0; bus.data_ready_clear = 0;
    bus.cmd_ready = 0; bus.rsp_valid = 0; bus.rsp_data = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dr"},    bus.data_ready, 0);
    chk({tag, "_full"},  bus.data_full, 0);
    chk({tag, "_cv"},    bus.cmd_valid, 0);
    chk({tag, "_cw"},    bus.cmd_write, 0);
    chk({tag, "_caddr"}, bus.cmd_addr, 0);
    chk({tag, "_wdat"},  bus.cmd_wdata, 0);
    chk({tag, "_wstrb"}, bus.cmd_wstrb, 0);
    chk({tag, "_rdat"},  bus.read_data, 0);
    chk({tag, "_perr"},  bus.proto_err, 0);
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    rstn = 0;
    step(); step();
    rstn = 1;
    step();
    chk_zero(tag);
  endtask

  task automatic wr_level(input logic lvl, input logic [31:0] a, input logic [7:0] d);
    bus.write_req   = lvl;
    bus.write_addr  = a;
    bus.write_data  = {32{d}};
    bus.write_wstrb = lvl ? '1 : '0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rstn = 0;
    idle_inputs();
    do_reset("rst0");

    // Write then drain (cmd_ready=1), then fill to full with cmd_ready=0, drop, drain.
    vq.push_back(mk(1,1,'h100,'hA5, 1,0,1,1,'h100,'hA5,0));
    vq.push_back(mk(1,1,'h100,'hA5, 1,0,0,0,'h0,'h00,0));
    vq.push_back(mk(0,1,'h0,'h00,   0,0,0,0,'h0,'h00,0));
    vq.push_back(mk(1,0,'hA1,'h11,  1,0,1,1,'hA1,'h11,0));
    vq.push_back(mk(0,0,'h0,'h00,   0,0,1,1,'hA1,'h11,0));
    vq.push_back(mk(1,0,'hA2,'h22,  1,0,1,1,'hA1,'h11,0));
    vq.push_back(mk(0,0,'h0,'h00,   0,0,1,1,'hA1,'h11,0));
    vq.push_back(mk(1,0,'hA3,'h33,  1,0,1,1,'hA1,'h11,0));
    vq.push_back(mk(0,0,'h0,'h00,   0,0,1,1,'hA1,'h11,0));
    vq.push_back(mk(1,0,'hA4,'h44,  1,1,1,1,'hA1,'h11,0));
    vq.push_back(mk(0,0,'h0,'h00,   0,1,1,1,'hA1,'h11,0));
    vq.push_back(mk(1,0,'hA5,'h55,  0,1,1,1,'hA1,'h11,1));
    vq.push_back(mk(0,0,'h0,'h00,   0,1,1,1,'hA1,'h11,1));
    vq.push_back(mk(0,1,'h0,'h00,   0,0,1,1,'hA2,'h22,1));
    vq.push_back(mk(0,1,'h0,'h00,   0,0,1,1,'hA3,'h33,1));
    vq.push_back(mk(0,1,'h0,'h00,   0,0,1,1,'hA4,'h44,1));
    vq.push_back(mk(0,1,'h0,'h00,   0,0,0,0,'h0,'h00,1));

    for (int i = 0; i < vq.size(); i++) begin
      wr_level(vq[i].wr, vq[i].addr, vq[i].db);
      bus.cmd_ready = vq[i].crdy;
      step();
      chk($sformatf("v%0d_dr", i),    bus.data_ready, vq[i].e_dr);
      chk($sformatf("v%0d_full", i),  bus.data_full,  vq[i].e_full);
      chk($sformatf("v%0d_cv", i),    bus.cmd_valid,  vq[i].e_cv);
      chk($sformatf("v%0d_cw", i),    bus.cmd_write,  vq[i].e_cw);
      chk($sformatf("v%0d_caddr", i), bus.cmd_addr,   vq[i].e_caddr);
      chk($sformatf("v%0d_wdat", i),  bus.cmd_wdata,  {32{vq[i].e_cdb}});
      chk($sformatf("v%0d_wstrb", i), bus.cmd_wstrb,  (vq[i].e_cv && vq[i].e_cw) ? {32{1'b1}} : 32'h0);
      chk($sformatf("v%0d_perr", i),  bus.proto_err,  vq[i].e_perr);
    end

    // Read ordering: two queued writes must pop before the read command.
    do_reset("rst1");
    wr_level(1, 'h10, 'h61); step();
    wr_level(0, 0, 0);       step();
    wr_level(1, 'h20, 'h62); step();
    wr_level(0, 0, 0);
    bus.read_req = 1; bus.read_addr = 'h200;
    step();
    chk("ro_w1_cw",   bus.cmd_write, 1);
    chk("ro_w1_addr", bus.cmd_addr, 'h10);
    bus.cmd_ready = 1;
    step();
    chk("ro_w2_cw",   bus.cmd_write, 1);
    chk("ro_w2_addr", bus.cmd_addr, 'h20);
    step();
    chk("ro_drain_cv", bus.cmd_valid, 0);
    step();
    chk("ro_rd_cv",   bus.cmd_valid, 1);
    chk("ro_rd_cw",   bus.cmd_write, 0);
    chk("ro_rd_addr", bus.cmd_addr, 'h200);
    chk("ro_rd_wdat", bus.cmd_wdata, 0);
    step();
    chk("ro_resp_cv", bus.cmd_valid, 0);
    chk("ro_resp_dr", bus.data_ready, 0);
    bus.cmd_ready = 0;
    bus.rsp_valid = 1; bus.rsp_data = 'h1234;
    step();
    bus.rsp_valid = 0;
    chk("ro_dr",   bus.data_ready, 1);
    chk("ro_rdat", bus.read_data, 'h1234);
    bus.data_ready_clear = 1;
    step();
    bus.data_ready_clear = 0;
    chk("ro_clr_dr",  bus.data_ready, 0);
    chk("ro_clr_st",  dut.state, ST_IDLE);
    chk("ro_perr",    bus.proto_err, 0);
    bus.read_req = 0;
    step();

    // Command stall: read command held 5 cycles with cmd_ready low.
    bus.read_req = 1; bus.read_addr = 'h300;
    step();
    chk("st_wait_cv", bus.cmd_valid, 0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("st%0d_cv", k),   bus.cmd_valid, 1);
      chk($sformatf("st%0d_cw", k),   bus.cmd_write, 0);
      chk($sformatf("st%0d_addr", k), bus.cmd_addr, 'h300);
      step();
    end
    bus.cmd_ready = 1;
    step();
    bus.cmd_ready = 0;
    chk("st_resp_st", dut.state, ST_RD_RESP);
    chk("st_resp_cv", bus.cmd_valid, 0);

    // Complete, release by lowering read_req, then a stray response.
    bus.rsp_valid = 1; bus.rsp_data = 'hBEEF;
    step();
    bus.rsp_valid = 0;
    chk("sr_rdat", bus.read_data, 'hBEEF);
    chk("sr_dr",   bus.data_ready, 1);
    bus.read_req = 0;
    step();
    chk("sr_rel_dr", bus.data_ready, 0);
    chk("sr_rel_st", dut.state, ST_IDLE);
    chk("sr_pre_perr", bus.proto_err, 0);
    bus.rsp_valid = 1; bus.rsp_data = 'hDEAD;
    step();
    bus.rsp_valid = 0;
    chk("sr_perr", bus.proto_err, 1);
    chk("sr_rdat_keep", bus.read_data, 'hBEEF);
    step();
    chk("sr_perr_sticky", bus.proto_err, 1);

    // Reset while a read waits for its response with two writes queued.
    do_reset("rst2");
    bus.read_req = 1; bus.read_addr = 'h400;
    step(); step();
    bus.cmd_ready = 1;
    step();
    bus.cmd_ready = 0;
    wr_level(1, 'h50, 'h71); step();
    wr_level(0, 0, 0);       step();
    wr_level(1, 'h60, 'h72); step();
    wr_level(0, 0, 0);
    chk("mr_pre_st", dut.state, ST_RD_RESP);
    chk("mr_pre_cv", bus.cmd_valid, 1);
    chk("mr_pre_addr", bus.cmd_addr, 'h50);
    #2 rstn = 0;
    #1 chk_zero("mr_async");
    idle_inputs();
    step(); step();
    rstn = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("mr_post%0d_cv", k), bus.cmd_valid, 0);
    end
    chk_zero("mr_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_data_pool.md
# axi_data_pool

Buffering stage between the AXI slave interface and the DDR3 command/scheduler core. Accepts posted single-beat writes into a small write FIFO and single-beat read requests, and presents them one at a time on a valid/ready command port toward the DRAM core. Returns read data with a `data_ready` / `data_ready_clear` handshake. Reads are ordered behind all previously accepted writes.

## Interface
Parameters:
- `AXI_DW`, 256: data width; `AXI_DW/8` strobe bits.
- `AXI_AW`, 32: address width.
- `WF_DEPTH`, 4: write FIFO entries; power of two, ≥2.

Ports:
- `axi_clk` in 1: single clock.
- `axi_rstn` in 1: asynchronous active-low reset.
- `write_req` in 1: write request level, held high by upstream until `data_ready` is seen.
- `write_addr` in AXI_AW: write address, valid with `write_req`.
- `write_data` in AXI_DW: write data, valid with `write_req`.
- `write_wstrb` in AXI_DW/8: write byte strobes, valid with `write_req`.
- `data_full` out 1: write FIFO holds `WF_DEPTH` entries.
- `read_req` in 1: read request level, held high until the read completes.
- `read_addr` in AXI_AW: read address, valid with `read_req`.
- `data_ready` out 1: write posted, or read data valid on `read_data`.
- `data_ready_clear` in 1: upstream consumed read data.
- `read_data` out AXI_DW: returned read data, registered.
- `cmd_valid` out 1: command to DRAM core.
- `cmd_ready` in 1: DRAM core accepts the command.
- `cmd_write` out 1: 1 = write, 0 = read.
- `cmd_addr` out AXI_AW: command address.
- `cmd_wdata` out AXI_DW: command write data.
- `cmd_wstrb` out AXI_DW/8: command write strobes.
- `rsp_valid` in 1: one-cycle pulse; read data from DRAM core.
- `rsp_data` in AXI_DW: read data, valid with `rsp_valid`.
- `proto_err` out 1: sticky flag for a dropped write or an unexpected `rsp_valid`.

## Operation
- **Request detection.** Requests are level signals. A new request is the rising edge of `write_req` or `read_req` against a registered copy of that signal.
- **Write push.**
  - On a `write_req` rise with the FIFO not full: push {addr, data, wstrb}.
  - On a rise while full: the entry is dropped and `proto_err` is set.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- **Write drain.** While the FIFO is non-empty:
  - `cmd_valid`=1, `cmd_write`=1, cmd fields = FIFO head.
  - Pop on `cmd_valid & cmd_ready`.
- **Read FSM states.**
  - **IDLE**: a `read_req` rise latches `read_addr` → WAIT_DRAIN.
  - **WAIT_DRAIN**: FIFO empty and no push this cycle → RD_CMD.
  - **RD_CMD**: `cmd_valid`=1, `cmd_write`=0, `cmd_addr` = latched address, data/strb = 0. On `cmd_ready` → RD_RESP.
  - **RD_RESP**: on `rsp_valid`, `read_data` ← `rsp_data`, `data_ready` ← 1 → RD_DONE.
  - **RD_DONE**: on `data_ready_clear`=1 or `read_req`=0, `data_ready` ← 0 → IDLE.
- **Command priority.** Write FIFO head always has priority; the FSM only reaches RD_CMD with the FIFO empty. `cmd_*` fields stay stable while `cmd_valid & ~cmd_ready`.
- **Write ack.**
  - `data_ready` ← 1 in the cycle after an accepted push (posted completion).
  - Cleared when `write_req`=0 or `data_ready_clear`=1.
  - A dropped write gets no ack.
- **Error cases.** `rsp_valid` outside RD_RESP is ignored and sets `proto_err`.
- **Clearing `proto_err`.** Only reset clears it.
- **Simultaneous rises of `write_req` and `read_req`.** Both are accepted. The read waits until that write has also drained.

## Timing
- **Reset values.** All outputs 0, FIFO empty, FSM IDLE, edge registers 0.
- **Reset mid-operation.** Flushes the FIFO and any pending read, with no further `cmd_valid`.
- **Write latency.**
  - `write_req` rises in cycle N → entry stored at the end of N.
  - `data_ready`, updated `data_full` and `cmd_valid` all appear in N+1.
- **Read latency.**
  - `read_req` rises in N with the FIFO empty → WAIT_DRAIN in N+1, RD_CMD (`cmd_valid`) in N+2.
  - `rsp_valid` in M → `data_ready` and `read_data` in M+1.
- **`data_full`.** Registered; reflects count after the previous edge's push/pop.
- **Pointers and count.** Pointers are `$clog2(WF_DEPTH)` bits and wrap modulo depth; count is one bit wider.

## Structure
- Package `ddr_ctrl_pkg`:
  - read-FSM state encoding (IDLE=0, WAIT_DRAIN=1, RD_CMD=2, RD_RESP=3, RD_DONE=4; 3 bits);
  - `AXI_DW` and `AXI_AW` defaults;
  - write-entry width constant `AXI_AW + AXI_DW + AXI_DW/8`.
- Sub-module `dp_wfifo`:
  - synchronous FIFO parameterised by width and depth;
  - ports: push, pop, din, dout, full, empty;
  - same clock and reset as `axi_data_pool`.

## Test plan
- **Write then drain.** Reset, then `write_req` rise with addr 0x100, data 0xA5.., strb all-ones, `cmd_ready`=1 → `data_ready`=1 and `cmd_valid`/`cmd_write`=1 with addr 0x100 one cycle later; FIFO empty after the pop.
- **FIFO full.** 4 writes with `cmd_ready`=0 → `data_full`=1 after the 4th; a 5th rise is dropped and `proto_err`=1.
- **Read ordering.** Two writes queued, then `read_req` at 0x200 → read command issued only after both writes pop; `rsp_data`=0x1234 → `read_data`=0x1234, `data_ready`=1; `data_ready_clear` → 0, FSM IDLE.
- **Command stall.** Hold `cmd_ready`=0 for 5 cycles during RD_CMD → `cmd_*` outputs stable; `cmd_ready` pulse → RD_RESP.
- **Stray response.** `rsp_valid` pulse while IDLE → `proto_err`=1, `read_data` unchanged.
- **Reset mid-operation.** `axi_rstn` low during RD_RESP with 2 writes queued → all outputs 0, `data_full`=0, no `cmd_valid` after release.
